// File: rtl/axi4_sram_sched_pkg.sv
// Shared types and AXI4 encodings for the AXI4-to-SRAM burst scheduler.
// Holds the FSM state enum, the latched-burst context and the burst legality check.
package axi4_sram_sched_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ
  } state_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
  } burst_ctx_t;

  // A burst is unserviceable if its beats are wider than the SRAM word,
  // it uses the reserved burst type, or it is a WRAP of illegal length.
  function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size,
                                     input logic [1:0] burst, input logic [2:0] max_size);
    burst_err = (size > max_size) || (burst == 2'b11) ||
                ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

endpackage

// File: rtl/axi4_sram_sched_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts within a 4KB page.
module axi4_sram_sched_addr_gen
  import axi4_sram_sched_pkg::*;
(
  input  logic [11:0] i_addr,
  input  logic [3:0]  i_len,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [11:0] o_next_addr
);

  logic [11:0] w_incr;
  logic [4:0]  w_beats;
  logic [11:0] w_wrap_bytes;
  logic [11:0] w_wrap_lo;
  logic [12:0] w_sum;
  logic [12:0] w_limit;

  always_comb begin
    w_incr       = 12'd1 << i_size;
    w_beats      = {1'b0, i_len} + 5'd1;
    w_wrap_bytes = {7'd0, w_beats} << i_size;
    w_wrap_lo    = i_addr & ~(w_wrap_bytes - 12'd1);
    // 13-bit sums so a window ending exactly at 4KB does not alias to 0
    w_sum        = {1'b0, i_addr} + {1'b0, w_incr};
    w_limit      = {1'b0, w_wrap_lo} + {1'b0, w_wrap_bytes};
    o_next_addr  = (i_addr & ~(w_incr - 12'd1)) + w_incr;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (w_sum >= w_limit) ? w_wrap_lo : w_sum[11:0];
      default:     ;
    endcase
  end

endmodule

// File: rtl/axi4_sram_sched.sv
// AXI4 slave serving one burst at a time from a single-port SRAM with
// one-cycle read latency; read/write arbitration is round-robin.
module axi4_sram_sched
  import axi4_sram_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [ID_WIDTH-1:0]            awid_i,
  input  logic [11:0]                    awaddr_i,
  input  logic [3:0]                     awlen_i,
  input  logic [2:0]                     awsize_i,
  input  logic [1:0]                     awburst_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wlast_i,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  output logic [ID_WIDTH-1:0]            bid_o,
  output logic [1:0]                     bresp_o,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  input  logic [ID_WIDTH-1:0]            arid_i,
  input  logic [11:0]                    araddr_i,
  input  logic [3:0]                     arlen_i,
  input  logic [2:0]                     arsize_i,
  input  logic [1:0]                     arburst_i,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [ID_WIDTH-1:0]            rid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rlast_o,
  output logic                           sram_en_o,
  output logic                           sram_we_o,
  output logic [11-$clog2(DATA_WIDTH/8):0] sram_addr_o,
  output logic [DATA_WIDTH/8-1:0]        sram_wstrb_o,
  output logic [DATA_WIDTH-1:0]          sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

  localparam int         OFFS     = $clog2(DATA_WIDTH/8);
  localparam logic [2:0] MAX_SIZE = 3'(OFFS);

  state_t              r_state, w_state_nxt;
  burst_ctx_t          r_ctx, w_new_ctx;
  logic [3:0]          r_cnt;
  logic                r_left;
  logic                r_prio_rd;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_wlast_err;
  logic [1:0]          r_bresp, r_rresp;
  logic                r_rvalid, r_rlast;

  logic        w_ar_hs, w_aw_hs, w_w_hs, w_issue, w_last_mis;
  logic [11:0] w_next_addr;

  axi4_sram_sched_addr_gen u_addr_gen (
    .i_addr      (r_ctx.addr),
    .i_len       (r_ctx.len),
    .i_size      (r_ctx.size),
    .i_burst     (r_ctx.burst),
    .o_next_addr (w_next_addr)
  );

  always_comb begin
    w_state_nxt = r_state;
    awready_o   = 1'b0;
    arready_o   = 1'b0;
    wready_o    = 1'b0;
    sram_en_o   = 1'b0;
    sram_we_o   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        arready_o = arvalid_i && (!awvalid_i || r_prio_rd);
        awready_o = awvalid_i && (!arvalid_i || !r_prio_rd);
        if (arready_o)      w_state_nxt = ST_READ;
        else if (awready_o) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          sram_en_o = !r_ctx.err;
          sram_we_o = !r_ctx.err;
          if (r_cnt == 4'd0) w_state_nxt = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (bready_i) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        w_issue   = r_left && (!r_rvalid || rready_i);
        sram_en_o = w_issue && !r_ctx.err;
        if (r_rvalid && rready_i && r_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ar_hs    = arvalid_i && arready_o;
  assign w_aw_hs    = awvalid_i && awready_o;
  assign w_w_hs     = wvalid_i && wready_o;
  assign w_last_mis = wlast_i != (r_cnt == 4'd0);

  always_comb begin
    w_new_ctx.addr  = w_ar_hs ? araddr_i  : awaddr_i;
    w_new_ctx.len   = w_ar_hs ? arlen_i   : awlen_i;
    w_new_ctx.size  = w_ar_hs ? arsize_i  : awsize_i;
    w_new_ctx.burst = w_ar_hs ? arburst_i : awburst_i;
    w_new_ctx.err   = burst_err(w_new_ctx.len, w_new_ctx.size, w_new_ctx.burst, MAX_SIZE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prio_rd   <= 1'b1;
      r_id        <= '0;
      r_left      <= 1'b0;
      r_wlast_err <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
    end else begin
      if (w_ar_hs || w_aw_hs) begin
        r_prio_rd   <= ~r_prio_rd;
        r_id        <= w_ar_hs ? arid_i : awid_i;
        r_left      <= 1'b1;
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        if (w_last_mis) r_wlast_err <= 1'b1;
        if (r_cnt == 4'd0)
          r_bresp <= (r_ctx.err || r_wlast_err || w_last_mis) ? RESP_SLVERR : RESP_OKAY;
      end
      // read beat issued this cycle appears on R next cycle
      if (w_issue) begin
        r_rvalid <= 1'b1;
        r_rlast  <= (r_cnt == 4'd0);
        r_rresp  <= r_ctx.err ? RESP_SLVERR : RESP_OKAY;
        if (r_cnt == 4'd0) r_left <= 1'b0;
      end else if (r_rvalid && rready_i) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_ar_hs || w_aw_hs) begin
      r_ctx <= w_new_ctx;
      r_cnt <= w_new_ctx.len;
    end else if (w_w_hs || w_issue) begin
      r_ctx.addr <= w_next_addr;
      r_cnt      <= r_cnt - 4'd1;
    end
  end

  assign sram_addr_o  = r_ctx.addr[11:OFFS];
  assign sram_wdata_o = wdata_i;
  assign sram_wstrb_o = wstrb_i;
  assign rdata_o      = sram_rdata_i;
  assign bvalid_o     = (r_state == ST_WRESP);
  assign bid_o        = r_id;
  assign bresp_o      = r_bresp;
  assign rid_o        = r_id;
  assign rresp_o      = r_rresp;
  assign rvalid_o     = r_rvalid;
  assign rlast_o      = r_rlast;

endmodule

// File: tb/tb_axi4_sram_sched.sv
// Directed bench for axi4_sram_sched: burst table plus arbitration and stall/reset sequences.
module tb_axi4_sram_sched;

  localparam int DW = 64;
  localparam int IW = 4;
  localparam logic [63:0] DBASE = 64'hD00D_0000_0000_0000;

  logic          clk, rst_n;
  logic          awvalid, awready, arvalid, arready, wvalid, wready, wlast;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [11:0]   awaddr, araddr;
  logic [3:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata, sram_wdata, sram_rdata;
  logic [7:0]    wstrb, sram_wstrb;
  logic          bvalid, bready, rvalid, rready, rlast;
  logic          sram_en, sram_we;
  logic [8:0]    sram_addr;
  logic [63:0]   mem [0:511];

  int n_cmp = 0;
  int n_err = 0;

  axi4_sram_sched #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .awvalid_i(awvalid), .awready_o(awready), .awid_i(awid), .awaddr_i(awaddr),
    .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid), .araddr_i(araddr),
    .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp),
    .rlast_o(rlast),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wstrb_o(sram_wstrb), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_wstrb[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    bit              wr;
    logic [11:0]     addr;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      wl;
    logic [3:0][8:0] words;
    bit              en;
    logic [1:0]      resp;
    bit              cd;
    logic [3:0][63:0] d;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(bit wr, logic [11:0] addr, logic [3:0] len, logic [2:0] size,
                              logic [1:0] burst, logic [3:0] wl, logic [8:0] w0, logic [8:0] w1,
                              logic [8:0] w2, logic [8:0] w3, bit en, logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.wl = wl;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.en = en; v.resp = resp; v.cd = 1'b0; v.d = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [11:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    bit ok;
    ok = 0;
    arvalid = 1; arid = id; araddr = a; arlen = l; arsize = s; arburst = b;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (arready) ok = 1;
      tick();
    end
    arvalid = 0;
    chk("ar_handshake", ok, 1);
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [11:0] a, input logic [3:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    bit ok;
    ok = 0;
    awvalid = 1; awid = id; awaddr = a; awlen = l; awsize = s; awburst = b;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (awready) ok = 1;
      tick();
    end
    awvalid = 0;
    chk("aw_handshake", ok, 1);
  endtask

  task automatic wait_b(input logic [IW-1:0] id, input logic [1:0] resp);
    bit ok;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (bvalid) begin
        ok = 1;
        chk("wresp_sram_en", sram_en, 0);
        chk("bresp", bresp, resp);
        chk("bid", bid, id);
      end else begin
        tick();
      end
    end
    chk("bvalid_seen", ok, 1);
    bready = 1;
    tick();
    bready = 0;
    @(negedge clk);
    chk("bvalid_cleared", bvalid, 0);
    tick();
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   issued, beats;
    bit   done;
    v = vecs[k];
    if (v.wr) begin
      send_aw(IW'(k), v.addr, v.len, v.size, v.burst);
      for (int b = 0; b <= int'(v.len); b++) begin
        wvalid = 1; wstrb = 8'hFF; wlast = v.wl[b];
        wdata = DBASE + 64'(b) + (64'(k) << 16);
        @(negedge clk);
        chk("wready", wready, 1);
        chk("w_sram_en", sram_en, v.en);
        if (v.en) begin
          chk("w_sram_we", sram_we, 1);
          chk("w_sram_addr", sram_addr, v.words[b]);
          chk("w_sram_wdata", sram_wdata, wdata);
        end
        tick();
      end
      wvalid = 0; wlast = 0;
      wait_b(IW'(k), v.resp);
    end else begin
      rready = 1;
      send_ar(IW'(k), v.addr, v.len, v.size, v.burst);
      issued = 0; beats = 0; done = 0;
      for (int c = 1; c <= 30 && !done; c++) begin
        @(negedge clk);
        if (sram_en) begin
          chk("r_sram_we", sram_we, 0);
          if (issued == 0) chk("first_issue_cycle", c, 1);
          if (issued < 4) chk("r_sram_addr", sram_addr, v.words[issued]);
          issued++;
        end
        if (rvalid) begin
          if (beats == 0) chk("first_rvalid_cycle", c, 2);
          chk("rresp", rresp, v.resp);
          chk("rid", rid, k);
          chk("rlast", rlast, beats == int'(v.len));
          if (v.cd && beats < 4) chk("rdata", rdata, v.d[beats]);
          if (rlast) done = 1;
          beats++;
        end
        tick();
      end
      chk("r_done", done, 1);
      chk("r_beats", beats, int'(v.len) + 1);
      chk("r_issues", issued, v.en ? int'(v.len) + 1 : 0);
    end
  endtask

  initial begin
    logic [63:0] cap_data;
    logic [8:0]  cap_addr;
    bit          ok;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap_data;
    logic [8:0]  cap_addr;
    bit          ok;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    sram_rdata = '0;
    rst_n = 0;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0; rready = 0;

    vecs[0]  = mk(1, 12'h038, 4'd3, 3'd3, 2'b10, 4'b1000, 9'd7, 9'd4, 9'd5, 9'd6, 1, 2'b00);
    vecs[1]  = mk(0, 12'h010, 4'd3, 3'd3, 2'b01, 4'b0000, 9'd2, 9'd3, 9'd4, 9'd5, 1, 2'b00);
    vecs[2]  = mk(0, 12'h020, 4'd3, 3'd3, 2'b01, 4'b0000, 9'd4, 9'd5, 9'd6, 9'd7, 1, 2'b00);
    vecs[2].cd = 1;
    vecs[2].d[0] = DBASE + 64'd1;
    vecs[2].d[1] = DBASE + 64'd2;
    vecs[2].d[2] = DBASE + 64'd3;
    vecs[2].d[3] = DBASE + 64'd0;
    vecs[3]  = mk(0, 12'h020, 4'd3, 3'd3, 2'b00, 4'b0000, 9'd4, 9'd4, 9'd4, 9'd4, 1, 2'b00);
    vecs[4]  = mk(0, 12'h008, 4'd1, 3'd2, 2'b01, 4'b0000, 9'd1, 9'd1, 9'd0, 9'd0, 1, 2'b00);
    vecs[5]  = mk(0, 12'h000, 4'd3, 3'd4, 2'b01, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 0, 2'b10);
    vecs[6]  = mk(0, 12'h040, 4'd0, 3'd3, 2'b11, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 0, 2'b10);
    vecs[7]  = mk(0, 12'h040, 4'd2, 3'd3, 2'b10, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 0, 2'b10);
    vecs[8]  = mk(1, 12'h100, 4'd1, 3'd3, 2'b01, 4'b0001, 9'd32, 9'd33, 9'd0, 9'd0, 1, 2'b10);
    vecs[9]  = mk(1, 12'h100, 4'd1, 3'd3, 2'b01, 4'b0010, 9'd32, 9'd33, 9'd0, 9'd0, 1, 2'b00);
    vecs[10] = mk(1, 12'h000, 4'd0, 3'd4, 2'b01, 4'b0001, 9'd0, 9'd0, 9'd0, 9'd0, 0, 2'b10);
    vecs[11] = mk(1, 12'h038, 4'd3, 3'd3, 2'b10, 4'b0000, 9'd7, 9'd4, 9'd5, 9'd6, 1, 2'b10);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_sram_en", sram_en, 0);
    tick();
    rst_n = 1;
    tick();

    // simultaneous AW/AR twice: read wins first, then write
    awvalid = 1; awid = 4'd6; awaddr = 12'h018; awlen = 0; awsize = 3'd3; awburst = 2'b01;
    arvalid = 1; arid = 4'd5; araddr = 12'h010; arlen = 0; arsize = 3'd3; arburst = 2'b01;
    rready = 1;
    @(negedge clk);
    chk("arb1_arready", arready, 1);
    chk("arb1_awready", awready, 0);
    tick();
    arvalid = 0;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (rvalid && rlast) begin
        ok = 1;
        chk("arb_rid", rid, 5);
      end
      tick();
    end
    chk("arb_read_done", ok, 1);
    arvalid = 1;
    @(negedge clk);
    chk("arb2_awready", awready, 1);
    chk("arb2_arready", arready, 0);
    tick();
    awvalid = 0; arvalid = 0;
    wvalid = 1; wlast = 1; wstrb = 8'hFF; wdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("arb_w_en", sram_en, 1);
    chk("arb_w_addr", sram_addr, 3);
    tick();
    wvalid = 0; wlast = 0;
    wait_b(4'd6, 2'b00);

    for (int k = 0; k < 12; k++) run_vec(k);

    // mid-burst stall, then reset
    rready = 1;
    send_ar(4'd9, 12'h000, 4'd3, 3'd3, 2'b01);
    tick();
    rready = 0;
    @(negedge clk);
    chk("stall_rvalid", rvalid, 1);
    chk("stall_en", sram_en, 0);
    cap_data = rdata;
    cap_addr = sram_addr;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("stall_hold_rvalid", rvalid, 1);
      chk("stall_hold_en", sram_en, 0);
      chk("stall_hold_rdata", rdata, cap_data);
      chk("stall_hold_addr", sram_addr, cap_addr);
      chk("stall_hold_rid", rid, 9);
      chk("stall_hold_rlast", rlast, 0);
      chk("stall_hold_rresp", rresp, 0);
    end
    tick();
    rst_n = 0;
    #1;
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rid", rid, 0);
    chk("arst_sram_en", sram_en, 0);
    rready = 1;
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_rvalid", rvalid, 0);
      chk("post_rst_en", sram_en, 0);
      chk("post_rst_bvalid", bvalid, 0);
      chk("post_rst_arready", arready, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
